// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command scheduler: refresh timer, init/refresh/write/read grant FSM and pin mux.
// Optional macro SDRAM_RR_EN: round-robin write/read tie breaking (default is fixed write-first).
module sdram_cmd_arbiter #(
   parameter int REF_PERIOD = 390,
   parameter int CNT_W      = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_done,
   input  logic [3:0]  init_cmd,
   input  logic [12:0] init_addr,
   input  logic        ref_end,
   input  logic [3:0]  ref_cmd,
   input  logic        wr_req,
   input  logic        wr_end,
   input  logic [3:0]  wr_cmd,
   input  logic [12:0] wr_addr,
   input  logic [1:0]  wr_ba,
   input  logic        rd_req,
   input  logic        rd_end,
   input  logic [3:0]  rd_cmd,
   input  logic [12:0] rd_addr,
   input  logic [1:0]  rd_ba,
   output logic        ref_en,
   output logic        wr_en,
   output logic        rd_en,
   output logic        ref_pending,
   output logic        ref_overrun,
   output logic [3:0]  sdram_cmd,
   output logic [12:0] sdram_addr,
   output logic [1:0]  sdram_ba
);

   localparam logic [3:0]       CMD_NOP  = 4'b0111;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARBIT,
      S_REFRESH,
      S_WRITE,
      S_READ
   } state_t;

   state_t            state_q;
   logic              ref_en_q, wr_en_q, rd_en_q;
   logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
   logic              ref_pending_q, ref_pending_d;
   logic              ref_overrun_q, ref_overrun_d;
   logic              ref_clr, ref_exp;
   logic              grant_wr, grant_rd;
`ifdef SDRAM_RR_EN
   logic              last_wr_q;
`endif

   // Refresh interval timer; a clear on the REFRESH-entry edge beats a coincident expiry.
   always_comb begin
      ref_clr       = (state_q == S_ARBIT) && ref_pending_q;
      ref_exp       = (state_q != S_IDLE) && (ref_cnt_q == CNT_LAST);
      ref_cnt_d     = ref_cnt_q;
      if (state_q != S_IDLE)
         ref_cnt_d = ref_exp ? '0 : ref_cnt_q + CNT_W'(1);
      ref_pending_d = ref_clr ? 1'b0 : (ref_exp ? 1'b1 : ref_pending_q);
      ref_overrun_d = ref_overrun_q | (ref_exp & ref_pending_q & ~ref_clr);
   end

   always_comb begin
`ifdef SDRAM_RR_EN
      grant_wr = wr_req && !(rd_req && last_wr_q);
`else
      grant_wr = wr_req;
`endif
      grant_rd = rd_req && !grant_wr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         ref_en_q      <= 1'b0;
         wr_en_q       <= 1'b0;
         rd_en_q       <= 1'b0;
         ref_cnt_q     <= '0;
         ref_pending_q <= 1'b0;
         ref_overrun_q <= 1'b0;
`ifdef SDRAM_RR_EN
         last_wr_q     <= 1'b0;
`endif
      end else begin
         ref_cnt_q     <= ref_cnt_d;
         ref_pending_q <= ref_pending_d;
         ref_overrun_q <= ref_overrun_d;
         case (state_q)
            S_IDLE: if (init_done) state_q <= S_ARBIT;
            S_ARBIT: begin
               if (ref_pending_q) begin
                  state_q  <= S_REFRESH;
                  ref_en_q <= 1'b1;
               end else if (grant_wr) begin
                  state_q  <= S_WRITE;
                  wr_en_q  <= 1'b1;
`ifdef SDRAM_RR_EN
                  last_wr_q <= 1'b1;
`endif
               end else if (grant_rd) begin
                  state_q  <= S_READ;
                  rd_en_q  <= 1'b1;
`ifdef SDRAM_RR_EN
                  last_wr_q <= 1'b0;
`endif
               end
            end
            S_REFRESH: if (ref_end) begin
               state_q  <= S_ARBIT;
               ref_en_q <= 1'b0;
            end
            S_WRITE: if (wr_end) begin
               state_q <= S_ARBIT;
               wr_en_q <= 1'b0;
            end
            S_READ: if (rd_end) begin
               state_q <= S_ARBIT;
               rd_en_q <= 1'b0;
            end
            default: begin
               state_q  <= S_IDLE;
               ref_en_q <= 1'b0;
               wr_en_q  <= 1'b0;
               rd_en_q  <= 1'b0;
            end
         endcase
      end
   end

   // Pins follow the state register directly, so the granted block's command lands this cycle.
   always_comb begin
      sdram_cmd  = CMD_NOP;
      sdram_addr = '0;
      sdram_ba   = '0;
      case (state_q)
         S_IDLE: begin
            sdram_cmd  = init_cmd;
            sdram_addr = init_addr;
         end
         S_REFRESH: sdram_cmd = ref_cmd;
         S_WRITE: begin
            sdram_cmd  = wr_cmd;
            sdram_addr = wr_addr;
            sdram_ba   = wr_ba;
         end
         S_READ: begin
            sdram_cmd  = rd_cmd;
            sdram_addr = rd_addr;
            sdram_ba   = rd_ba;
         end
         default: ;
      endcase
   end

   assign ref_en      = ref_en_q;
   assign wr_en       = wr_en_q;
   assign rd_en       = rd_en_q;
   assign ref_pending = ref_pending_q;
   assign ref_overrun = ref_overrun_q;

endmodule
